// File: rtl/ssi_pkg.sv
// ssi_pkg: SSI register map, status/control bit indices and sequencer state encodings
package ssi_pkg;
    localparam logic [7:0] CR0_OFS  = 8'h00;
    localparam logic [7:0] CR1_OFS  = 8'h04;
    localparam logic [7:0] DR_OFS   = 8'h08;
    localparam logic [7:0] SR_OFS   = 8'h0C;
    localparam logic [7:0] CPSR_OFS = 8'h10;
    localparam int SR_TFE  = 0;
    localparam int SR_TNF  = 1;
    localparam int SR_RNE  = 2;
    localparam int SR_BSY  = 4;
    localparam int CR1_SSE = 1;
    localparam logic [15:0] CR1_EN = 16'(1 << CR1_SSE);
    typedef enum logic [3:0] {
        IDLE, W_CR1_OFF, W_CR0, W_CPSR, W_CR1_EN, POLL_TNF, WAIT_TX,
        W_DR, POLL_RNE, R_DR, PUSH_RX, DRAIN, W_DIS, DONE
    } state_t;
    typedef enum logic [1:0] {X_IDLE, X_SETUP, X_ACCESS} xact_t;
endpackage

// File: rtl/ssi_xfer_ctrl_if.sv
// ssi_xfer_ctrl_if: APB bus between the transfer sequencer and the SSI slave
interface ssi_xfer_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    modport master(output psel, penable, pwrite, paddr, pwdata, input prdata, pready);
    modport slave(input psel, penable, pwrite, paddr, pwdata, output prdata, pready);
endinterface

// File: rtl/apb_master_xact.sv
// apb_master_xact: runs one APB transfer (SETUP then ACCESS until pready) per start request
module apb_master_xact
    import ssi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  p_clk,
    input  logic                  p_resetn,
    input  logic                  start,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rdata,
    ssi_xfer_ctrl_if.master       m
);
    xact_t                 st;
    logic                  write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    always_ff @(posedge p_clk or negedge p_resetn) begin
        if (!p_resetn) begin
            st      <= X_IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            st <= (st == X_IDLE)  ? (start ? X_SETUP : X_IDLE) :
                  (st == X_SETUP) ? X_ACCESS :
                  (m.pready ? X_IDLE : X_ACCESS);
            if (st == X_IDLE && start) begin
                write_q <= write;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
        end
    end

    assign m.psel    = st != X_IDLE;
    assign m.penable = st == X_ACCESS;
    assign m.pwrite  = write_q;
    assign m.paddr   = addr_q;
    assign m.pwdata  = wdata_q;
    assign busy      = st != X_IDLE;
    assign done      = st == X_ACCESS && m.pready;
    assign rdata     = m.prdata;
endmodule

// File: rtl/ssi_xfer_ctrl.sv
// ssi_xfer_ctrl: configures the SSI slave over APB and streams a burst of frames through it
module ssi_xfer_ctrl
    import ssi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_W      = 8,
    parameter int POLL_MAX   = 1023
) (
    input  logic             p_clk,
    input  logic             p_resetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [15:0]      cmd_cr0,
    input  logic [7:0]       cmd_cpsdvsr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [15:0]      tx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic [15:0]      rx_data,
    output logic             done,
    output logic             err,
    ssi_xfer_ctrl_if.master  m
);
    localparam int PW = $clog2(POLL_MAX + 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);

    state_t                state, state_n;
    logic [15:0]           cr0_q, tx_q, rx_q;
    logic [7:0]            cps_q;
    logic [LEN_W-1:0]      remaining;
    logic [PW-1:0]         poll_cnt;
    logic                  err_q, poll_ok, poll_last, timeout;
    logic                  x_start, x_write, x_busy, x_done;
    logic [7:0]            x_ofs;
    logic [DATA_WIDTH-1:0] x_wdata, x_rdata;
    logic                  unused_hi;

    apb_master_xact #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_xact (
        .p_clk(p_clk), .p_resetn(p_resetn), .start(x_start), .write(x_write),
        .addr(ADDR_WIDTH'(x_ofs)), .wdata(x_wdata), .busy(x_busy), .done(x_done),
        .rdata(x_rdata), .m(m)
    );

    assign poll_last = poll_cnt == POLL_LAST;
    assign timeout   = x_done && !poll_ok && poll_last && (state inside {POLL_TNF, POLL_RNE, DRAIN});
    assign unused_hi = ^x_rdata[DATA_WIDTH-1:16];

    // Every bus state issues exactly one request whenever the engine is free
    always_comb begin
        x_start = !x_busy && !(state inside {IDLE, WAIT_TX, PUSH_RX, DONE});
        x_write = 1'b1;
        x_ofs   = CR1_OFS;
        x_wdata = '0;
        poll_ok = 1'b0;
        state_n = state;
        case (state)
            IDLE:      state_n = cmd_valid ? W_CR1_OFF : IDLE;
            W_CR1_OFF: state_n = x_done ? W_CR0 : state;
            W_CR0: begin
                x_ofs   = CR0_OFS;
                x_wdata = DATA_WIDTH'(cr0_q);
                state_n = x_done ? W_CPSR : state;
            end
            W_CPSR: begin
                x_ofs   = CPSR_OFS;
                x_wdata = DATA_WIDTH'(cps_q);
                state_n = x_done ? W_CR1_EN : state;
            end
            W_CR1_EN: begin
                x_wdata = DATA_WIDTH'(CR1_EN);
                state_n = !x_done ? state : (remaining == '0) ? DRAIN : POLL_TNF;
            end
            POLL_TNF: begin
                x_write = 1'b0;
                x_ofs   = SR_OFS;
                poll_ok = x_rdata[SR_TNF];
                state_n = !x_done ? state : poll_ok ? WAIT_TX : poll_last ? W_DIS : state;
            end
            WAIT_TX: state_n = tx_valid ? W_DR : state;
            W_DR: begin
                x_ofs   = DR_OFS;
                x_wdata = DATA_WIDTH'(tx_q);
                state_n = x_done ? POLL_RNE : state;
            end
            POLL_RNE: begin
                x_write = 1'b0;
                x_ofs   = SR_OFS;
                poll_ok = x_rdata[SR_RNE];
                state_n = !x_done ? state : poll_ok ? R_DR : poll_last ? W_DIS : state;
            end
            R_DR: begin
                x_write = 1'b0;
                x_ofs   = DR_OFS;
                state_n = x_done ? PUSH_RX : state;
            end
            PUSH_RX: state_n = !rx_ready ? state : (remaining == LEN_W'(1)) ? DRAIN : POLL_TNF;
            DRAIN: begin
                x_write = 1'b0;
                x_ofs   = SR_OFS;
                poll_ok = !x_rdata[SR_BSY] && x_rdata[SR_TFE];
                state_n = (x_done && (poll_ok || poll_last)) ? W_DIS : state;
            end
            W_DIS:   state_n = x_done ? DONE : state;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge p_clk or negedge p_resetn) begin
        if (!p_resetn) begin
            state     <= IDLE;
            cr0_q     <= '0;
            cps_q     <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            remaining <= '0;
            poll_cnt  <= '0;
            err_q     <= 1'b0;
        end else begin
            state    <= state_n;
            poll_cnt <= (state_n != state) ? '0 : poll_cnt + PW'(x_done);
            err_q    <= (state == IDLE) ? 1'b0 : err_q | timeout;
            if (state == IDLE && cmd_valid) begin
                cr0_q     <= cmd_cr0;
                cps_q     <= cmd_cpsdvsr;
                remaining <= cmd_len;
            end
            if (tx_ready) tx_q <= tx_data;
            if (state == R_DR && x_done) rx_q <= x_rdata[15:0];
            if (rx_valid && rx_ready) remaining <= remaining - 1'b1;
        end
    end

    assign cmd_ready = state == IDLE;
    assign tx_ready  = state == WAIT_TX && tx_valid;
    assign rx_valid  = state == PUSH_RX;
    assign rx_data   = rx_q;
    assign done      = state == DONE;
    assign err       = done && err_q;
endmodule

// File: tb/tb_ssi_xfer_ctrl.sv
// tb_ssi_xfer_ctrl: directed vectors against an APB SSI slave model with hand-computed bus traces
module tb_ssi_xfer_ctrl;
    logic        p_clk = 1'b0;
    logic        p_resetn = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [15:0] cmd_cr0 = '0;
    logic [7:0]  cmd_cpsdvsr = '0;
    logic [7:0]  cmd_len = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [15:0] tx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b1;
    logic [15:0] rx_data;
    logic        done, err, cmd_ready;

    int          vectors = 0;
    int          miscompares = 0;
    logic        clr = 1'b1;
    logic [31:0] sr_val = 32'h1;
    int          wait_n = 0;
    int          stall_frame = -1;
    logic [15:0] tx_words [4];
    logic [15:0] rx_words [4];
    logic [1:0]  dr_idx, tx_idx;
    int          wcnt, waits, stall_seen;
    logic        unstable, stall_bad;
    logic [15:0] stall_data;
    logic [31:0] s_addr, s_wdata;
    logic        s_write;
    logic [31:0] log_q[$];
    logic [31:0] exp_q[$];
    logic [15:0] rx_got[$];

    always #5 p_clk = ~p_clk;

    ssi_xfer_ctrl_if bus();

    ssi_xfer_ctrl #(.POLL_MAX(4)) dut (
        .p_clk(p_clk), .p_resetn(p_resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_cr0(cmd_cr0), .cmd_cpsdvsr(cmd_cpsdvsr), .cmd_len(cmd_len),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .done(done), .err(err), .m(bus)
    );

    assign bus.pready = bus.psel && bus.penable && (wcnt >= wait_n);
    assign bus.prdata = (bus.paddr[7:0] == 8'h0C) ? sr_val : {16'h0, rx_words[dr_idx]};
    assign tx_data    = tx_words[tx_idx];

    // Slave side: transfer log, wait states, and address/data stability across SETUP/ACCESS
    always @(posedge p_clk) begin
        if (clr) begin
            log_q.delete();
            rx_got.delete();
            dr_idx <= '0;
            tx_idx <= '0;
            wcnt <= 0;
            waits <= 0;
            unstable <= 1'b0;
        end else begin
            if (bus.psel && !bus.penable) begin
                s_addr <= bus.paddr;
                s_wdata <= bus.pwdata;
                s_write <= bus.pwrite;
            end else if (bus.psel && (bus.paddr != s_addr || bus.pwdata != s_wdata || bus.pwrite != s_write))
                unstable <= 1'b1;
            if (bus.psel && bus.penable && !bus.pready) begin
                wcnt <= wcnt + 1;
                waits <= waits + 1;
            end else wcnt <= 0;
            if (bus.psel && bus.penable && bus.pready) begin
                log_q.push_back({7'b0, bus.pwrite, bus.paddr[7:0], bus.pwrite ? bus.pwdata[15:0] : bus.prdata[15:0]});
                if (!bus.pwrite && bus.paddr[7:0] == 8'h08) dr_idx <= dr_idx + 1'b1;
            end
            if (tx_ready) tx_idx <= tx_idx + 1'b1;
            if (rx_valid && rx_ready) rx_got.push_back(rx_data);
        end
    end

    always @(negedge p_clk) begin
        if (clr) begin
            stall_seen = 0;
            stall_bad = 1'b0;
            rx_ready = 1'b1;
        end else if (rx_valid && rx_got.size() == stall_frame && stall_seen < 5) begin
            rx_ready = 1'b0;
            if ((stall_seen > 0 && rx_data != stall_data) || bus.psel) stall_bad = 1'b1;
            stall_data = rx_data;
            stall_seen++;
        end else rx_ready = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] e(input logic w, input logic [7:0] a, input logic [15:0] d);
        return {7'b0, w, a, d};
    endfunction

    task automatic cfg_exp(input logic [15:0] cr0, input logic [7:0] cps);
        exp_q.delete();
        exp_q.push_back(e(1'b1, 8'h04, 16'h0));
        exp_q.push_back(e(1'b1, 8'h00, cr0));
        exp_q.push_back(e(1'b1, 8'h10, {8'h0, cps}));
        exp_q.push_back(e(1'b1, 8'h04, 16'h2));
    endtask

    task automatic check_seq(input string tag);
        check({tag, "_len"}, log_q.size(), exp_q.size());
        foreach (exp_q[i])
            check($sformatf("%s_acc%0d", tag, i), (i < log_q.size()) ? log_q[i] : 32'hDEAD_BEEF, exp_q[i]);
    endtask

    task automatic clear_tb;
        clr = 1'b1;
        repeat (2) @(posedge p_clk);
        #1 clr = 1'b0;
    endtask

    task automatic run_cmd(input logic [15:0] cr0, input logic [7:0] cps, input logic [7:0] len);
        @(negedge p_clk);
        cmd_cr0 = cr0;
        cmd_cpsdvsr = cps;
        cmd_len = len;
        cmd_valid = 1'b1;
        @(posedge p_clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic want_err);
        for (int n = 0; n < 3000; n++) begin
            @(negedge p_clk);
            if (done) break;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_err"}, err, want_err);
    endtask

    task automatic frame_exp(input logic [15:0] tx, input logic [15:0] rx, input logic [15:0] sr);
        exp_q.push_back(e(1'b0, 8'h0C, sr));
        exp_q.push_back(e(1'b1, 8'h08, tx));
        exp_q.push_back(e(1'b0, 8'h0C, sr));
        exp_q.push_back(e(1'b0, 8'h08, rx));
    endtask

    initial begin
        tx_words = '{16'hA5A5, 16'h0, 16'h0, 16'h0};
        rx_words = '{16'h5A5A, 16'h0, 16'h0, 16'h0};
        #2 p_resetn = 1'b0;
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_psel", bus.psel, 0);
        check("rst_penable", bus.penable, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_rx_valid", rx_valid, 0);
        tx_valid = 1'b1;
        #1 check("rst_tx_ready", tx_ready, 0);
        repeat (3) @(posedge p_clk);
        @(negedge p_clk) p_resetn = 1'b1;
        clear_tb();

        // len=0: configure, drain, disable
        sr_val = 32'h1;
        run_cmd(16'h0107, 8'd2, 8'd0);
        wait_done("t1", 1'b0);
        cfg_exp(16'h0107, 8'd2);
        exp_q.push_back(e(1'b0, 8'h0C, 16'h1));
        exp_q.push_back(e(1'b1, 8'h04, 16'h0));
        check_seq("t1");
        clear_tb();

        // single frame
        sr_val = 32'h7;
        run_cmd(16'h0F07, 8'd4, 8'd1);
        wait_done("t2", 1'b0);
        cfg_exp(16'h0F07, 8'd4);
        frame_exp(16'hA5A5, 16'h5A5A, 16'h7);
        exp_q.push_back(e(1'b0, 8'h0C, 16'h7));
        exp_q.push_back(e(1'b1, 8'h04, 16'h0));
        check_seq("t2");
        check("t2_rx_n", rx_got.size(), 1);
        check("t2_rx0", rx_got[0], 16'h5A5A);
        @(negedge p_clk) check("t2_rx_hold", rx_data, 16'h5A5A);
        clear_tb();

        // three frames, consumer stalls five cycles on the second
        tx_words = '{16'hA001, 16'hA002, 16'hA003, 16'h0};
        rx_words = '{16'h1111, 16'h2222, 16'h3333, 16'h0};
        stall_frame = 1;
        run_cmd(16'h0207, 8'd2, 8'd3);
        wait_done("t3", 1'b0);
        cfg_exp(16'h0207, 8'd2);
        frame_exp(16'hA001, 16'h1111, 16'h7);
        frame_exp(16'hA002, 16'h2222, 16'h7);
        frame_exp(16'hA003, 16'h3333, 16'h7);
        exp_q.push_back(e(1'b0, 8'h0C, 16'h7));
        exp_q.push_back(e(1'b1, 8'h04, 16'h0));
        check_seq("t3");
        check("t3_rx_n", rx_got.size(), 3);
        check("t3_rx0", rx_got[0], 16'h1111);
        check("t3_rx1", rx_got[1], 16'h2222);
        check("t3_rx2", rx_got[2], 16'h3333);
        check("t3_stall_cycles", stall_seen, 5);
        check("t3_stall_quiet", stall_bad, 0);
        stall_frame = -1;
        clear_tb();

        // TX FIFO never reports space: timeout after POLL_MAX reads
        sr_val = 32'h0;
        tx_words = '{16'hA5A5, 16'h0, 16'h0, 16'h0};
        rx_words = '{16'h5A5A, 16'h0, 16'h0, 16'h0};
        run_cmd(16'h0107, 8'd2, 8'd1);
        wait_done("t4", 1'b1);
        cfg_exp(16'h0107, 8'd2);
        repeat (4) exp_q.push_back(e(1'b0, 8'h0C, 16'h0));
        exp_q.push_back(e(1'b1, 8'h04, 16'h0));
        check_seq("t4");
        check("t4_no_tx", tx_idx, 0);
        check("t4_no_rx", rx_got.size(), 0);
        clear_tb();

        // three wait states per access
        sr_val = 32'h7;
        wait_n = 3;
        run_cmd(16'h0F07, 8'd4, 8'd1);
        wait_done("t5", 1'b0);
        cfg_exp(16'h0F07, 8'd4);
        frame_exp(16'hA5A5, 16'h5A5A, 16'h7);
        exp_q.push_back(e(1'b0, 8'h0C, 16'h7));
        exp_q.push_back(e(1'b1, 8'h04, 16'h0));
        check_seq("t5");
        check("t5_stable", unstable, 0);
        check("t5_waits", waits, 30);
        check("t5_rx0", rx_got[0], 16'h5A5A);
        wait_n = 0;
        clear_tb();

        // reset while polling for RX data
        sr_val = 32'h3;
        run_cmd(16'h0107, 8'd2, 8'd1);
        for (int n = 0; n < 300; n++) begin
            @(negedge p_clk);
            if (log_q.size() >= 6 && bus.psel) break;
        end
        check("t6_in_poll_rne", (log_q.size() >= 6) && bus.psel, 1);
        p_resetn = 1'b0;
        #1;
        check("t6_psel_drop", bus.psel, 0);
        check("t6_penable_drop", bus.penable, 0);
        repeat (2) @(negedge p_clk);
        p_resetn = 1'b1;
        #1;
        check("t6_cmd_ready", cmd_ready, 1);
        check("t6_rx_valid", rx_valid, 0);
        clear_tb();
        sr_val = 32'h1;
        run_cmd(16'h0107, 8'd2, 8'd0);
        wait_done("t6b", 1'b0);
        cfg_exp(16'h0107, 8'd2);
        exp_q.push_back(e(1'b0, 8'h0C, 16'h1));
        exp_q.push_back(e(1'b1, 8'h04, 16'h0));
        check_seq("t6b");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
